// File: rtl/mul_div_unit_if.sv
// Handshake and result bus for mul_div_unit: operation request, move-to-HI/LO
// strobes and the registered HI/LO results.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_write;
    logic             lo_write;
    logic [WIDTH-1:0] write_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, src_a, src_b, hi_write, lo_write, write_data,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, src_a, src_b, hi_write, lo_write, write_data,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: WIDTH-step shift-add / restoring divide on
// magnitudes, then a sign fix. Define MULDIV_DIV_EN to include the divide datapath.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_a;
    logic               r_neg_b;
    logic [WIDTH-1:0]   r_b_mag;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;

    // Sign flags already fold in the signed-op bit, so unsigned ops never negate
    always_comb begin
        w_a_neg    = bus.op[0] & bus.src_a[WIDTH-1];
        w_b_neg    = bus.op[0] & bus.src_b[WIDTH-1];
        w_a_mag    = w_a_neg ? -bus.src_a : bus.src_a;
        w_b_mag    = w_b_neg ? -bus.src_b : bus.src_b;
        w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b_mag} : '0);
        w_prod     = {r_acc_hi, r_acc_lo};
        w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    end

`ifdef MULDIV_DIV_EN
    logic [1:0]       r_op;
    logic             r_dbz;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quo_fix;

    // A zero divisor makes every step subtract: quotient all ones, remainder = |a|
    always_comb begin
        w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_div_ge    = w_div_shift >= {1'b0, r_b_mag};
        w_div_diff  = w_div_shift[WIDTH-1:0] - r_b_mag;
        w_rem_fix   = r_neg_a ? -r_acc_hi : r_acc_hi;
        w_quo_fix   = (r_neg_a ^ r_neg_b) ? -r_acc_lo : r_acc_lo;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_b_mag  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_op     <= '0;
            r_dbz    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_neg_a  <= w_a_neg;
                        r_neg_b  <= w_b_neg;
                        r_b_mag  <= w_b_mag;
                        r_acc_hi <= '0;
                        r_acc_lo <= w_a_mag;
                        r_cnt    <= '0;
`ifdef MULDIV_DIV_EN
                        r_op     <= bus.op;
                        r_dbz    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
`else
                        if (bus.op[1]) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= CALC;
                        end
`endif
                    end else begin
                        if (bus.hi_write) r_hi <= bus.write_data;
                        if (bus.lo_write) r_lo <= bus.write_data;
                    end
                end

                CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= FIX;
`ifdef MULDIV_DIV_EN
                    if (r_op[1]) begin
                        r_acc_hi <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ge};
                    end else
`endif
                    begin
                        r_acc_hi <= w_mul_sum[WIDTH:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    end
                end

                FIX: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
`ifdef MULDIV_DIV_EN
                    if (r_op[1]) begin
                        r_hi  <= w_rem_fix;
                        r_lo  <= (r_b_mag == '0) ? '1 : w_quo_fix;
                        r_dbz <= (r_b_mag == '0);
                    end else
`endif
                    begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
`ifdef MULDIV_DIV_EN
    assign bus.div_by_zero = r_dbz;
`else
    assign bus.div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops
// compared against an arithmetic reference model; honours MULDIV_DIV_EN.
module tb_mul_div_unit;
    localparam int WIDTH = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mul_div_unit_if #(.WIDTH(WIDTH)) bus ();
    mul_div_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [WIDTH-1:0] m_hi = '0;
    logic [WIDTH-1:0] m_lo = '0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ed);
        logic [63:0] up;
        longint      sa, sb, sp, q, r;
        sa = $signed(a);
        sb = $signed(b);
        ed = 1'b0;
        case (op)
            2'b00: begin up = {32'b0, a} * {32'b0, b}; {eh, el} = up; end
            2'b01: begin sp = sa * sb; {eh, el} = sp; end
            default: begin
                if (b == 32'd0) begin
                    el = '1; eh = a; ed = 1'b1;
                end else if (op == 2'b10) begin
                    el = a / b; eh = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    el = 32'(q); eh = 32'(r);
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit with_write);
        logic [31:0] eh, el, hold_hi, hold_lo;
        logic        ed;
        int          lat;
        model(op, a, b, eh, el, ed);
        hold_hi = m_hi;
        hold_lo = m_lo;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        if (with_write) begin
            bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.write_data = $urandom;
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hi_write = 1'b0; bus.lo_write = 1'b0;
        bus.src_a = $urandom; bus.src_b = $urandom; bus.op = 2'($urandom);
        check_val("dbz_clear", bus.div_by_zero, 0);
        if (op[1] && !DIV_EN) begin
            check_val("nodiv_done_busy", {bus.done, bus.busy}, 2'b10);
            @(posedge clk); #1;
            check_val("nodiv_after_busy", {bus.done, bus.busy}, 2'b00);
            check_val("nodiv_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
            return;
        end
        check_val("busy_after_start", bus.busy, 1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == WIDTH) check_val("hilo_hold", {bus.hi, bus.lo}, {hold_hi, hold_lo});
        end while (!bus.done && lat < 200);
        check_val("latency", lat, WIDTH + 1);
        check_val("result", {bus.hi, bus.lo}, {eh, el});
        check_val("dbz_busy_at_done", {bus.div_by_zero, bus.busy}, {ed, 1'b0});
        m_hi = eh;
        m_lo = el;
        @(posedge clk); #1;
        check_val("done_one_cycle", bus.done, 0);
    endtask

    task automatic mv_write(input bit hi_sel, input logic [31:0] d);
        @(negedge clk);
        if (hi_sel) bus.hi_write = 1'b1; else bus.lo_write = 1'b1;
        bus.write_data = d;
        @(posedge clk); #1;
        bus.hi_write = 1'b0; bus.lo_write = 1'b0;
        if (hi_sel) m_hi = d; else m_lo = d;
        check_val("move_to", {bus.hi, bus.lo}, {m_hi, m_lo});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb, got_hi, got_lo;
        int          ndone;

        bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
        bus.hi_write = 1'b0; bus.lo_write = 1'b0; bus.write_data = '0;
        #1 reset = 1'b1;
        #2;
        check_val("reset_ctl", {bus.busy, bus.done, bus.div_by_zero}, 3'b000);
        check_val("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b01, -32'sd3, 32'd7, 1'b0);
        run_op(2'b11, -32'sd7, 32'd2, 1'b0);
        run_op(2'b10, 32'd5, 32'd0, 1'b0);
        run_op(2'b00, 32'd2, 32'd3, 1'b0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b11, -32'sd9, 32'd0, 1'b0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(2'b10, 32'd9, 32'd3, 1'b0);
        run_op(2'b00, 32'd2, 32'd5, 1'b1);
        mv_write(1'b1, 32'hA5A5_0F0F);
        mv_write(1'b0, 32'h1234_5678);

        // Second start and lo_write arrive while a MULTU 4*4 is in progress
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd4; bus.src_b = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd9; bus.src_b = 32'd3;
        bus.lo_write = 1'b1; bus.write_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.lo_write = 1'b0;
        ndone = 0; got_hi = '1; got_lo = '1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin ndone++; got_hi = bus.hi; got_lo = bus.lo; end
        end
        check_val("ignore_ndone", ndone, 1);
        check_val("ignore_result", {got_hi, got_lo}, {32'd0, 32'd16});
        m_hi = '0; m_lo = 32'd16;

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = $urandom_range(1, 9);
                2: begin ra = 32'h8000_0000; rb = '1; end
                3: ra = $urandom_range(0, 100);
                default: ;
            endcase
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of an operation aborts it
        mv_write(1'b1, 32'hCAFE_0001);
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIV_EN ? 2'b11 : 2'b01; bus.src_a = 32'd100; bus.src_b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("abort_ctl", {bus.busy, bus.done, bus.div_by_zero}, 3'b000);
        check_val("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check_val("abort_no_done", ndone, 0);
        check_val("abort_hilo_after", {bus.hi, bus.lo}, 64'd0);
        run_op(DIV_EN ? 2'b10 : 2'b00, 32'd100, 32'd7, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width; legal values are even and at least 8.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, width of the iteration counter.
REQ-003 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a new operation; sampled only while idle.
REQ-006 op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 src_a, src_b  input  WIDTH each  multiplicand/multiplier, or dividend/divisor.
REQ-008 hi_write, lo_write  input  1 each  move-to-HI / move-to-LO strobes.
REQ-009 write_data  input  WIDTH  data for the move-to strobes.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when hi/lo hold a new result.
REQ-012 hi, lo  output  WIDTH each  registered result: upper product half or remainder (hi), lower product half or quotient (lo).
REQ-013 div_by_zero  output  1  registered flag set when a division with src_b==0 completes.

Function
REQ-014 FSM states: IDLE, CALC, FIX; only IDLE accepts start.
REQ-015 In IDLE, start=1 at edge N latches op and operands; busy=1 after edge N; the operation enters CALC.
REQ-016 CALC runs exactly WIDTH iterations, one per edge: shift-add for multiply, restoring shift-subtract for divide, both on operand magnitudes.
REQ-017 FIX applies sign correction and writes hi/lo at edge N+WIDTH+1, then returns to IDLE.
REQ-018 After edge N+WIDTH+1, busy=0 and done=1 for exactly one cycle; total latency is WIDTH+1 edges.
REQ-019 MULTU/MULT produce the full 2*WIDTH-bit unsigned or two's-complement product, split as {hi,lo}.
REQ-020 Signed DIV truncates the quotient toward zero; the remainder takes the dividend's sign.
REQ-021 DIV of the most negative value by -1 gives lo=most negative value and hi=0, with no error flag.
REQ-022 Division by zero gives lo=all ones, hi=src_a unchanged, and sets div_by_zero=1.
REQ-023 div_by_zero clears at the next accepted start.
REQ-024 start while busy is ignored; operands are not re-latched.
REQ-025 hi_write/lo_write in IDLE update hi/lo at the next edge; they are ignored while busy.
REQ-026 If start and a move-to strobe occur in the same IDLE cycle, start wins and the write is dropped.
REQ-027 hi/lo hold their values during CALC and change only at FIX or on a move-to write.
REQ-028 op and operand inputs may change freely after the accepting edge.

Reset
REQ-029 reset=1 forces state IDLE, busy=0, done=0, hi=0, lo=0 and div_by_zero=0 immediately, without waiting for a clock edge.
REQ-030 reset during CALC or FIX aborts the operation: no done pulse and no hi/lo update.
REQ-031 The first start after reset deasserts is accepted normally.

Configuration
REQ-032 Macro MULDIV_DIV_EN defined: all four ops are implemented as specified above.
REQ-033 MULDIV_DIV_EN undefined: divide datapath is absent; div_by_zero is tied to 0.
REQ-034 With the macro undefined, a DIVU/DIV start pulses done one cycle after acceptance, busy stays 0, and hi/lo are unchanged.
REQ-035 With the macro undefined, multiply behaviour and latency are identical to the enabled build.

Verification (WIDTH=32, MULDIV_DIV_EN defined unless stated)
REQ-036 MULTU 0xFFFFFFFF*0xFFFFFFFF -> done 33 edges after start, hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 DIVU 5/0 -> lo=0xFFFFFFFF, hi=0x00000005, div_by_zero=1; next MULTU 2*3 -> div_by_zero=0, lo=6.
REQ-039 Second start 5 cycles into a MULTU 4*4 -> ignored; a single done with lo=16; lo_write while busy has no effect.
REQ-040 Reset asserted 10 cycles into DIV 100/7 -> outputs zero at once, no done; after release, DIVU 100/7 -> lo=14, hi=2.
REQ-041 MULDIV_DIV_EN undefined: DIVU 9/3 -> done next cycle, busy never high, hi/lo unchanged.
